// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical memory port between the I-cache and D-cache.
// One transaction in flight; round-robin on contention; sticky watchdog on a silent memory.
module pmem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_terr;

    logic             w_i_pend;
    logic             w_d_pend;
    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_timeout;
    logic             w_serve;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_i_pend  = i_read;
    assign w_d_pend  = d_read | d_write;
    assign w_serve   = (r_state != IDLE);
    // Saturate so a disabled watchdog can never wrap back onto a match.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (w_d_pend && (!w_i_pend || !r_last_d)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = SERVE_D;
                end else if (w_i_pend) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_state_nxt = IDLE;
                end else if ((TIMEOUT_CYC != 0) && (w_cnt_inc == TO_VAL)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_i || w_grant_d) begin
                r_cnt    <= '0;
                r_last_d <= w_grant_d;
                r_addr   <= w_grant_d ? d_address : i_address;
                r_wr     <= w_grant_d & d_write;
                if (w_grant_d) r_wdata <= d_wdata;
            end else if (w_serve && !pmem_resp) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_timeout) r_terr <= 1'b1;
        end
    end

    assign pmem_read    = w_serve & ~r_wr;
    assign pmem_write   = w_serve & r_wr;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_resp       = pmem_resp & (r_state == SERVE_I);
    assign d_resp       = pmem_resp & (r_state == SERVE_D);
    assign i_rdata      = i_resp ? pmem_rdata : '0;
    assign d_rdata      = d_resp ? pmem_rdata : '0;
    assign timeout_err  = r_terr;

endmodule
